// File: rtl/display_scan_capture_pkg.sv
// Purpose: shared constants for the display digit-scan capture and digit-select driver.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Contents: one-hot digit-select codes DIG0..DIG3, capture FSM state codes,
// frame/digit widths, and a helper mapping a digit index to its select code.
package display_scan_capture_pkg;

    localparam int FRAME_W = 16;
    localparam int DIGIT_W = 4;
    localparam int NUM_DIG = 4;

    // Leftmost digit is driven by the MSB of the select bus.
    localparam logic [3:0] DIG0 = 4'b1000;
    localparam logic [3:0] DIG1 = 4'b0100;
    localparam logic [3:0] DIG2 = 4'b0010;
    localparam logic [3:0] DIG3 = 4'b0001;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // Select code for a digit index, as produced by the digit-select driver.
    function automatic logic [3:0] dig_sel(input logic [1:0] idx);
        return DIG0 >> idx;
    endfunction

endpackage

// File: rtl/display_scan_capture_mux_encoder.sv
// Purpose: one-hot digit select to 2-bit digit index plus valid flag.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of the select bus.
//
// Ports:
//   mux - one-hot digit select (DIG0..DIG3)
//   idx - decoded digit index, 0 when vld=0
//   vld - 1 when exactly one select bit is set
module mux_encoder
    import display_scan_capture_pkg::*;
(
    input  logic [3:0] mux,
    output logic [1:0] idx,
    output logic       vld
);

    always_comb begin
        idx = 2'd0;
        vld = 1'b1;
        case (mux)
            DIG0:    idx = 2'd0;
            DIG1:    idx = 2'd1;
            DIG2:    idx = 2'd2;
            DIG3:    idx = 2'd3;
            default: vld = 1'b0;   // zero or multi-hot select
        endcase
    end

endmodule

// File: rtl/display_scan_capture.sv
// Purpose: rebuild a 4-digit frame from a multiplexed display scan (mux/digit/strobe).
// Latency: frame/frame_valid and all error pulses appear 1 cycle after the strobe that causes them.
// Backpressure: none; every strobe is consumed in its own cycle, outputs are pulses.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   mux, digit      - one-hot digit select and digit value, qualified by strobe
//   frame           - last complete frame, digit 0 in [15:12] .. digit 3 in [3:0]
//   frame_valid     - one-cycle pulse when frame is updated
//   count           - index of last strobe carrying a valid one-hot select
//   onehot_err      - pulse: strobe with zero/multi-hot select
//   seq_err         - pulse: strobe for a digit out of scan order
//   timeout         - pulse: STALL_LIMIT cycles without strobe mid-frame
module display_scan_capture
    import display_scan_capture_pkg::*;
#(
    parameter int STALL_LIMIT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         mux,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               strobe,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid,
    output logic [1:0]         count,
    output logic               onehot_err,
    output logic               seq_err,
    output logic               timeout
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [0:0]                        state;
    logic [1:0]                        expected;
    logic [0:NUM_DIG-1][DIGIT_W-1:0]   slots;
    logic [STALL_W-1:0]                stall_cnt;

    logic [1:0] sel_idx;
    logic       sel_vld;

    mux_encoder u_mux_encoder (
        .mux (mux),
        .idx (sel_idx),
        .vld (sel_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            expected    <= 2'd0;
            slots       <= '0;
            stall_cnt   <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            count       <= 2'd0;
            onehot_err  <= 1'b0;
            seq_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            onehot_err  <= 1'b0;
            seq_err     <= 1'b0;
            timeout     <= 1'b0;

            if (strobe) begin
                stall_cnt <= '0;
                if (!sel_vld) begin
                    // Bad select poisons the frame in either state.
                    onehot_err <= 1'b1;
                    state      <= ST_IDLE;
                end else begin
                    count <= sel_idx;
                    if (state == ST_IDLE) begin
                        // Only a digit-0 strobe can open a frame; others are
                        // simply the tail of a scan we joined late.
                        if (sel_idx == 2'd0) begin
                            slots[0] <= digit;
                            expected <= 2'd1;
                            state    <= ST_COLLECT;
                        end
                    end else if (sel_idx == expected) begin
                        slots[sel_idx] <= digit;
                        if (sel_idx == 2'd3) begin
                            // Slot 3 is taken from the bus directly since the
                            // slot register only updates at this same edge.
                            frame       <= {slots[0], slots[1], slots[2], digit};
                            frame_valid <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            expected <= expected + 2'd1;
                        end
                    end else begin
                        seq_err <= 1'b1;
                        if (sel_idx == 2'd0) begin
                            // A new scan started early: resync on it.
                            slots[0] <= digit;
                            expected <= 2'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            end else if (state == ST_COLLECT) begin
                // Counter is held at zero in IDLE, so it always starts clean.
                if (stall_cnt == STALL_LAST) begin
                    timeout   <= 1'b1;
                    state     <= ST_IDLE;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + STALL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/display_scan_capture.md
DISPLAY_SCAN_CAPTURE -- requirements
Module: display_scan_capture

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 1000: max cycles allowed between strobes inside a frame.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port mux, input, 4: one-hot digit select; 4'b1000=digit 0, 0100=1, 0010=2, 0001=3.
REQ-005 SHALL have port digit, input, 4: digit value accompanying mux.
REQ-006 SHALL have port strobe, input, 1: qualifies mux/digit for one cycle.
REQ-007 SHALL have port frame, output, 16: last complete frame; digit 0 in [15:12], digit 3 in [3:0].
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when frame updates.
REQ-009 SHALL have port count, output, 2: index of last accepted valid strobe.
REQ-010 SHALL have ports onehot_err, seq_err, timeout, output, 1 each: one-cycle error pulses.

Function
REQ-011 SHALL decode mux to a 2-bit index; valid only when exactly one bit is set.
REQ-012 SHALL implement FSM states IDLE (expect index 0) and COLLECT (expect index n+1, n = last captured).
REQ-013 SHALL ignore mux/digit on cycles where strobe=0, except for stall counting.
REQ-014 SHALL, in IDLE on strobe with index 0, store digit into slot 0, set expected=1, go to COLLECT.
REQ-015 SHALL, in IDLE on strobe with valid index 1..3, discard it, stay IDLE, no error pulse.
REQ-016 SHALL, in COLLECT on strobe with index equal to expected, store digit in that slot and increment expected.
REQ-017 SHALL, when slot 3 is stored, copy all four slots to frame and pulse frame_valid on the next cycle (latency 1), then return to IDLE.
REQ-018 SHALL keep frame unchanged between frame_valid pulses; partial frames never reach frame.
REQ-019 SHALL, on strobe with mux zero or multi-hot in any state, pulse onehot_err, discard the partial frame, and go to IDLE.
REQ-020 SHALL, in COLLECT on a valid but unexpected index, pulse seq_err; if index is 0, restart with digit in slot 0 and expected=1, else go to IDLE.
REQ-021 SHALL, in COLLECT, count consecutive cycles without strobe; on reaching STALL_LIMIT, pulse timeout and go to IDLE.
REQ-022 SHALL clear the stall counter on every strobe and on entry to IDLE; the counter is inactive in IDLE.
REQ-023 SHALL update count on every strobe with valid one-hot mux, regardless of sequence outcome.
REQ-024 SHALL register all outputs; no combinational path from input to output.
REQ-025 SHALL, when an error and frame completion coincide, report the error only; the frame is not published.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE; set frame=16'h0000, count=2'b00, and all capture slots to 0; clear the stall counter; deassert frame_valid, onehot_err, seq_err, timeout.
REQ-027 SHALL give rst priority over strobe; reset mid-frame discards the partial frame and emits no pulse.

Structure
REQ-028 SHALL place the one-hot select constants (DIG0..DIG3), FSM state encoding, and frame width in a shared package, shared with the display digit-select driver.
REQ-029 SHALL instantiate one combinational sub-module, mux_encoder (one-hot to index plus valid flag), kept separate for reuse.
REQ-030 SHALL size the stall counter as clog2(STALL_LIMIT+1) bits.

Verification
REQ-031 Strobes mux=1000/0100/0010/0001 with digits 1,2,3,4 on consecutive cycles -> frame=16'h1234, single frame_valid one cycle after the fourth strobe.
REQ-032 Strobe mux=1000 d=5, then mux=0010 -> seq_err pulse, IDLE, frame unchanged, no frame_valid.
REQ-033 Strobe mux=1000 d=7, then mux=1100 -> onehot_err pulse, IDLE; following full sequence 9,8,7,6 -> frame=16'h9876.
REQ-034 Strobe mux=1000, then no strobe for STALL_LIMIT cycles -> timeout pulse exactly at limit; a strobe at limit-1 instead -> no timeout.
REQ-035 rst=1 after three strobes of a frame -> all outputs zero next cycle; mux=0001 strobe after reset -> ignored, no error.
REQ-036 Strobes 1000,0100,1000 -> seq_err and restart; then 0100,0010,0001 -> frame published with the restarted digit 0.
